nexys_starship_game_timer: RTL and testbench



---
 rtl/nexys_starship_game_timer.sv | 164 ++++++++++++++++
 tb/tb_nexys_starship_game_timer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nexys_starship_game_timer.sv
// Nexys Starship survival stopwatch: BCD MM:SS on sys_clk using a clock-enable prescaler.
// Define NEXYS_STARSHIP_BEST_TIME_EN to add best-time tracking (best_* digits, new_record).
module nexys_starship_game_timer #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int PRESCALE_W    = 27
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       play_flag,
  input  logic       gameover_ctrl,
  input  logic       clear,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       sec_pulse,
  output logic       running,
  output logic       saturated
`ifdef NEXYS_STARSHIP_BEST_TIME_EN
  ,
  output logic [3:0] best_sec_ones,
  output logic [3:0] best_sec_tens,
  output logic [3:0] best_min_ones,
  output logic [3:0] best_min_tens,
  output logic       new_record
`endif
);

  localparam logic [PRESCALE_W-1:0] TERM_CNT = PRESCALE_W'(TICKS_PER_SEC - 1);
  localparam logic [15:0]           MAX_TIME = 16'h9959;

  typedef enum logic [1:0] {IDLE, RUN, FROZEN, SAT} state_t;

  state_t                state, state_next;
  logic [PRESCALE_W-1:0] presc;
  logic [15:0]           time_q;
  logic [15:0]           time_inc;
  logic                  count_en;
  logic                  tick;
  logic                  at_max;
  logic                  running_d;
  logic                  saturated_d;

  // One-second BCD increment; 99:59 is the ceiling and does not wrap.
  function automatic logic [15:0] bcd_time_inc(input logic [15:0] t);
    logic [15:0] n;
    n = t;
    if (t == MAX_TIME) return t;
    if (t[3:0] != 4'd9) begin
      n[3:0] = t[3:0] + 4'd1;
    end else begin
      n[3:0] = 4'd0;
      if (t[7:4] != 4'd5) begin
        n[7:4] = t[7:4] + 4'd1;
      end else begin
        n[7:4] = 4'd0;
        if (t[11:8] != 4'd9) begin
          n[11:8] = t[11:8] + 4'd1;
        end else begin
          n[11:8]  = 4'd0;
          n[15:12] = t[15:12] + 4'd1;
        end
      end
    end
    return n;
  endfunction

  assign count_en = (state == RUN) && play_flag && !gameover_ctrl && !clear;
  assign tick     = count_en && (presc == TERM_CNT);
  assign at_max   = (time_q == MAX_TIME);
  assign time_inc = bcd_time_inc(time_q);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      running   <= 1'b0;
      saturated <= 1'b0;
    end else begin
      state     <= state_next;
      running   <= running_d;
      saturated <= saturated_d;
    end
  end

  // clear outranks game over, which outranks a pending tick.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (play_flag && !gameover_ctrl) state_next = RUN;
        RUN: begin
          if (gameover_ctrl)     state_next = FROZEN;
          else if (tick && at_max) state_next = SAT;
        end
        SAT:     if (gameover_ctrl) state_next = FROZEN;
        FROZEN:  state_next = FROZEN;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    running_d   = (state_next == RUN);
    saturated_d = (state_next == SAT);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      presc     <= '0;
      time_q    <= '0;
      sec_pulse <= 1'b0;
    end else begin
      sec_pulse <= tick;
      if (clear) begin
        presc  <= '0;
        time_q <= '0;
      end else if (count_en) begin
        if (tick) begin
          presc  <= '0;
          time_q <= time_inc;
        end else begin
          presc <= presc + PRESCALE_W'(1);
        end
      end
    end
  end

  assign sec_ones = time_q[3:0];
  assign sec_tens = time_q[7:4];
  assign min_ones = time_q[11:8];
  assign min_tens = time_q[15:12];

`ifdef NEXYS_STARSHIP_BEST_TIME_EN
  logic [15:0] best_q;
  logic        freeze_entry;

  // Frozen digits equal the pre-edge digits because the tick is suppressed on entry.
  assign freeze_entry = (state_next == FROZEN) && (state != FROZEN);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      best_q     <= '0;
      new_record <= 1'b0;
    end else if (clear) begin
      new_record <= 1'b0;
    end else if (freeze_entry) begin
      if (time_q > best_q) begin
        best_q     <= time_q;
        new_record <= 1'b1;
      end else begin
        new_record <= 1'b0;
      end
    end
  end

  assign best_sec_ones = best_q[3:0];
  assign best_sec_tens = best_q[7:4];
  assign best_min_ones = best_q[11:8];
  assign best_min_tens = best_q[15:12];
`endif

endmodule

// File: tb/tb_nexys_starship_game_timer.sv
// Self-checking bench for nexys_starship_game_timer with an elapsed-seconds reference model.
module tb_nexys_starship_game_timer;

  localparam int TPS = 4;
  localparam int MAX_SECS = 99 * 60 + 59;
  localparam int S_IDLE = 0, S_RUN = 1, S_FROZEN = 2, S_SAT = 3;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       play_flag = 1'b0;
  logic       gameover_ctrl = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       sec_pulse, running, saturated;
  logic [15:0] dut_time;
`ifdef NEXYS_STARSHIP_BEST_TIME_EN
  logic [3:0] best_sec_ones, best_sec_tens, best_min_ones, best_min_tens;
  logic       new_record;
  logic [15:0] dut_best;
  assign dut_best = {best_min_tens, best_min_ones, best_sec_tens, best_sec_ones};
`endif

  assign dut_time = {min_tens, min_ones, sec_tens, sec_ones};

  nexys_starship_game_timer #(.TICKS_PER_SEC(TPS), .PRESCALE_W(3)) dut (
    .Clk(Clk), .Reset(Reset), .play_flag(play_flag), .gameover_ctrl(gameover_ctrl), .clear(clear),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
    .sec_pulse(sec_pulse), .running(running), .saturated(saturated)
`ifdef NEXYS_STARSHIP_BEST_TIME_EN
    , .best_sec_ones(best_sec_ones), .best_sec_tens(best_sec_tens),
    .best_min_ones(best_min_ones), .best_min_tens(best_min_tens), .new_record(new_record)
`endif
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  // Reference model: elapsed whole seconds plus cycles counted toward the next one.
  int m_st, m_secs, m_cnt, m_best;
  bit m_pulse, m_nr;

  function automatic logic [15:0] secs_to_bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_secs = 0; m_cnt = 0; m_pulse = 0; m_best = 0; m_nr = 0;
  endtask

  task automatic model_step();
    m_pulse = 0;
    if (!Reset) begin
      model_reset();
    end else if (clear) begin
      m_st = S_IDLE; m_secs = 0; m_cnt = 0; m_nr = 0;
    end else if (m_st == S_IDLE) begin
      if (play_flag && !gameover_ctrl) m_st = S_RUN;
    end else if (m_st == S_RUN || m_st == S_SAT) begin
      if (gameover_ctrl) begin
        m_st = S_FROZEN;
        m_nr = (m_secs > m_best);
        if (m_nr) m_best = m_secs;
      end else if (m_st == S_RUN && play_flag) begin
        m_cnt++;
        if (m_cnt == TPS) begin
          m_cnt = 0;
          m_pulse = 1;
          if (m_secs == MAX_SECS) m_st = S_SAT;
          else m_secs++;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge Clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge Clk);
      if (chk_en) begin
        chk("time", dut_time, secs_to_bcd(m_secs));
        chk("sec_pulse", 16'(sec_pulse), 16'(m_pulse));
        chk("running", 16'(running), 16'(m_st == S_RUN));
        chk("saturated", 16'(saturated), 16'(m_st == S_SAT));
`ifdef NEXYS_STARSHIP_BEST_TIME_EN
        chk("best", dut_best, secs_to_bcd(m_best));
        chk("new_record", 16'(new_record), 16'(m_nr));
`endif
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Clk);
      @(negedge Clk);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_time"}, dut_time, 16'h0000);
    chk({tag, "_pulse"}, 16'(sec_pulse), 16'h0);
    chk({tag, "_running"}, 16'(running), 16'h0);
    chk({tag, "_saturated"}, 16'(saturated), 16'h0);
`ifdef NEXYS_STARSHIP_BEST_TIME_EN
    chk({tag, "_best"}, dut_best, 16'h0000);
    chk({tag, "_new_record"}, 16'(new_record), 16'h0);
`endif
  endtask

  task automatic do_reset(input string tag);
    chk_en = 1'b0;
    Reset = 1'b0;
    play_flag = 1'b0; gameover_ctrl = 1'b0; clear = 1'b0;
    #1;
    chk_all_zero(tag);
    model_reset();
    cyc(2);
    Reset = 1'b1;
    chk_en = 1'b1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    #1;
    do_reset("reset");

    // First tick after IDLE->RUN plus four prescaler cycles; tenth second at cycle 41.
    play_flag = 1'b1;
    cyc(5);
    chk("t1_first_pulse", 16'(sec_pulse), 16'h1);
    chk("t1_first_time", dut_time, 16'h0001);
    cyc(36);
    chk("t1_ten_secs", dut_time, 16'h0010);
    chk("t1_ten_pulse", 16'(sec_pulse), 16'h1);

    // Game over with the prescaler at terminal count suppresses the tick.
    pulse_clear();
    cyc(16);
    gameover_ctrl = 1'b1;
    cyc(1);
    gameover_ctrl = 1'b0;
    chk("t4_frozen_time", dut_time, 16'h0003);
    chk("t4_frozen_pulse", 16'(sec_pulse), 16'h0);
    chk("t4_frozen_running", 16'(running), 16'h0);
    cyc(3);
    chk("t4_held_time", dut_time, 16'h0003);
    pulse_clear();
    play_flag = 1'b0;
    chk("t4_clear_time", dut_time, 16'h0000);
    chk("t4_clear_running", 16'(running), 16'h0);

    // Pause at 00:02 with one prescaler count consumed; three cycles remain.
    play_flag = 1'b1;
    cyc(10);
    play_flag = 1'b0;
    cyc(20);
    chk("t5_paused_time", dut_time, 16'h0002);
    play_flag = 1'b1;
    cyc(2);
    chk("t5_resume_nopulse", 16'(sec_pulse), 16'h0);
    cyc(1);
    chk("t5_resume_pulse", 16'(sec_pulse), 16'h1);
    chk("t5_resume_time", dut_time, 16'h0003);

    // Randomized play/pause/game-over/clear traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      play_flag = ($urandom % 10) < 7;
      gameover_ctrl = ($urandom % 50) == 0;
      clear = ($urandom % 40) == 0;
      cyc(1);
    end
    play_flag = 1'b0; gameover_ctrl = 1'b0; clear = 1'b0;

    // Best-time tracking: 00:05 record, then a shorter 00:03 run.
    do_reset("reset2");
    play_flag = 1'b1;
    cyc(21);
    gameover_ctrl = 1'b1;
    cyc(1);
    gameover_ctrl = 1'b0;
    chk("t6_freeze5_time", dut_time, 16'h0005);
`ifdef NEXYS_STARSHIP_BEST_TIME_EN
    chk("t6_best5", dut_best, 16'h0005);
    chk("t6_record1", 16'(new_record), 16'h1);
`endif
    pulse_clear();
    cyc(13);
    gameover_ctrl = 1'b1;
    cyc(1);
    gameover_ctrl = 1'b0;
    chk("t6_freeze3_time", dut_time, 16'h0003);
`ifdef NEXYS_STARSHIP_BEST_TIME_EN
    chk("t6_best_kept", dut_best, 16'h0005);
    chk("t6_record0", 16'(new_record), 16'h0);
`endif
    pulse_clear();
    cyc(10);

    // Asynchronous reset mid-run, away from any clock edge.
    chk_en = 1'b0;
    #2;
    Reset = 1'b0;
    #1;
    chk_all_zero("async");
    model_reset();
    cyc(1);
    do_reset("reset3");

    // Long run through 09:59 -> 10:00 and on to saturation at 99:59.
    play_flag = 1'b1;
    cyc(2400);
    chk("t2_0959", dut_time, 16'h0959);
    cyc(1);
    chk("t2_1000", dut_time, 16'h1000);
    chk("t2_pulse", 16'(sec_pulse), 16'h1);
    cyc(21599);
    chk("t3_9959", dut_time, 16'h9959);
    chk("t3_running", 16'(running), 16'h1);
    chk("t3_not_sat", 16'(saturated), 16'h0);
    cyc(1);
    chk("t3_sat_pulse", 16'(sec_pulse), 16'h1);
    chk("t3_sat_flag", 16'(saturated), 16'h1);
    chk("t3_sat_time", dut_time, 16'h9959);
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      chk("t3_sat_nopulse", 16'(sec_pulse), 16'h0);
      chk("t3_sat_hold", dut_time, 16'h9959);
      chk("t3_sat_stays", 16'(saturated), 16'h1);
    end
    gameover_ctrl = 1'b1;
    cyc(1);
    gameover_ctrl = 1'b0;
    chk("t3_sat_frozen", 16'(saturated), 16'h0);
    cyc(4);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
